// File: rtl/irq_pkg.sv
// Shared types and constants for the eight-line prioritised interrupt controller.
package irq_pkg;

    localparam int unsigned N_IRQ = 8;
    localparam int unsigned ID_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    function automatic logic [ID_W-1:0] onehot_to_idx(input logic [N_IRQ-1:0] oh);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (oh[ID_W'(i)]) idx = idx | ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_prio_ctrl_if.sv
// Interrupt controller bus: raw lines, mask write, CPU handshake and status.
interface irq_prio_ctrl_if;

    logic [irq_pkg::N_IRQ-1:0] irq;
    logic                      mask_we;
    logic [irq_pkg::N_IRQ-1:0] mask_wdata;
    logic                      int_ack;
    logic                      eoi;
    logic [irq_pkg::ID_W-1:0]  eoi_id;
    logic                      int_valid;
    logic [irq_pkg::ID_W-1:0]  int_id;
    logic [irq_pkg::N_IRQ-1:0] pending_o;
    logic [irq_pkg::N_IRQ-1:0] in_service_o;

    modport master (
        output irq, mask_we, mask_wdata, int_ack, eoi, eoi_id,
        input  int_valid, int_id, pending_o, in_service_o
    );

    modport slave (
        input  irq, mask_we, mask_wdata, int_ack, eoi, eoi_id,
        output int_valid, int_id, pending_o, in_service_o
    );

endinterface

// File: rtl/prio_onehot8.sv
// Combinational selector: one-hot of the highest set bit of an 8-bit request.
module prio_onehot8 (
    input  logic [7:0] req,
    output logic [7:0] gnt
);

    always_comb begin
        gnt = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (req[3'(i)]) gnt = 8'(1) << i;
        end
    end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Edge-captured, masked, nesting-aware interrupt controller with a valid/ack
// presentation to the CPU.
module irq_prio_ctrl
    import irq_pkg::*;
(
    input logic            clk,
    input logic            reset_n,
    irq_prio_ctrl_if.slave bus
);

    state_t state, state_n;

    logic [N_IRQ-1:0] irq_q, pending, mask, in_service;
    logic [N_IRQ-1:0] pending_n, in_service_n;
    logic [ID_W-1:0]  id_r, id_n;
    logic [N_IRQ-1:0] rise, hi_isr, allowed, eligible, win_oh;

    prio_onehot8 u_isr_sel  (.req(in_service), .gnt(hi_isr));
    prio_onehot8 u_elig_sel (.req(eligible),   .gnt(win_oh));

    assign rise = bus.irq & ~irq_q;
    // Only lines strictly above the highest in-service line may preempt it.
    assign allowed  = (hi_isr == '0) ? '1 : ~(hi_isr | (hi_isr - N_IRQ'(1)));
    assign eligible = pending & mask & allowed;

    always_comb begin
        state_n      = state;
        id_n         = id_r;
        pending_n    = pending;
        in_service_n = in_service;

        // EOI retires first so a same-cycle ack on that line re-sets it.
        if (bus.eoi) in_service_n[bus.eoi_id] = 1'b0;

        case (state)
            IDLE: begin
                if (eligible != '0) begin
                    id_n    = onehot_to_idx(win_oh);
                    state_n = REQ;
                end
            end
            REQ: begin
                if (bus.int_ack) begin
                    pending_n[id_r]    = 1'b0;
                    in_service_n[id_r] = 1'b1;
                    state_n            = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // New edges win over the ack clear.
        pending_n = pending_n | rise;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            irq_q      <= '0;
            pending    <= '0;
            mask       <= '0;
            in_service <= '0;
            id_r       <= '0;
        end else begin
            state      <= state_n;
            irq_q      <= bus.irq;
            pending    <= pending_n;
            in_service <= in_service_n;
            id_r       <= id_n;
            if (bus.mask_we) mask <= bus.mask_wdata;
        end
    end

    assign bus.int_valid    = (state == REQ);
    assign bus.int_id       = id_r;
    assign bus.pending_o    = pending;
    assign bus.in_service_o = in_service;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Bench for irq_prio_ctrl: directed vector table, hand-written corner sequences
// and random traffic against a behavioural model.
module tb_irq_prio_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    irq_prio_ctrl_if bus ();

    irq_prio_ctrl dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: per-line flags plus the line currently presented.
    bit m_pend[8];
    bit m_isr[8];
    bit m_mask[8];
    bit m_irq_q[8];
    bit m_busy;
    int m_id;

    typedef struct {
        logic [7:0] irq;
        logic       mask_we;
        logic [7:0] wdata;
        logic       ack;
        logic       eoi;
        logic [2:0] eid;
        logic       valid;
        logic [2:0] id;
        logic [7:0] pend;
        logic [7:0] isr;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [7:0] pack8(input bit a[8]);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = 0; m_isr[i] = 0; m_mask[i] = 0; m_irq_q[i] = 0;
        end
        m_busy = 0;
        m_id   = 0;
    endtask

    task automatic model_edge();
        int top_isr;
        int win;
        bit n_pend[8];
        bit n_isr[8];
        logic [7:0] irq_v;
        logic [7:0] wd_v;
        irq_v = bus.irq;
        wd_v  = bus.mask_wdata;
        top_isr = -1;
        for (int i = 0; i < 8; i++) if (m_isr[i]) top_isr = i;
        win = -1;
        for (int i = 7; i >= 0; i--)
            if (win < 0 && m_pend[i] && m_mask[i] && i > top_isr) win = i;
        n_pend = m_pend;
        n_isr  = m_isr;
        if (bus.eoi) n_isr[int'(bus.eoi_id)] = 0;
        if (!m_busy) begin
            if (win >= 0) begin
                m_busy = 1;
                m_id   = win;
            end
        end else if (bus.int_ack) begin
            n_pend[m_id] = 0;
            n_isr[m_id]  = 1;
            m_busy       = 0;
        end
        for (int i = 0; i < 8; i++) begin
            if (irq_v[i] && !m_irq_q[i]) n_pend[i] = 1;
            m_irq_q[i] = irq_v[i];
            if (bus.mask_we) m_mask[i] = wd_v[i];
        end
        m_pend = n_pend;
        m_isr  = n_isr;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("model_valid", 32'(bus.int_valid), 32'(m_busy));
        check("model_id", 32'(bus.int_id), 32'(m_id));
        check("model_pending", 32'(bus.pending_o), 32'(pack8(m_pend)));
        check("model_in_service", 32'(bus.in_service_o), 32'(pack8(m_isr)));
    endtask

    task automatic cyc(input logic [7:0] irq, input logic we, input logic [7:0] wd,
                       input logic ack, input logic eoi, input logic [2:0] eid);
        bus.irq        = irq;
        bus.mask_we    = we;
        bus.mask_wdata = wd;
        bus.int_ack    = ack;
        bus.eoi        = eoi;
        bus.eoi_id     = eid;
        step();
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_valid"}, 32'(bus.int_valid), 32'd0);
        check({nm, "_id"}, 32'(bus.int_id), 32'd0);
        check({nm, "_pending"}, 32'(bus.pending_o), 32'd0);
        check({nm, "_in_service"}, 32'(bus.in_service_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'h00, 1, 8'hFF, 0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00};
        vecs[1]  = '{8'h08, 0, 8'h00, 0, 0, 3'd0, 0, 3'd0, 8'h08, 8'h00};
        vecs[2]  = '{8'h00, 0, 8'h00, 0, 0, 3'd0, 1, 3'd3, 8'h08, 8'h00};
        vecs[3]  = '{8'h00, 0, 8'h00, 1, 0, 3'd0, 0, 3'd3, 8'h00, 8'h08};
        vecs[4]  = '{8'h00, 0, 8'h00, 0, 1, 3'd3, 0, 3'd3, 8'h00, 8'h00};
        vecs[5]  = '{8'h85, 0, 8'h00, 0, 0, 3'd0, 0, 3'd3, 8'h85, 8'h00};
        vecs[6]  = '{8'h00, 0, 8'h00, 0, 0, 3'd0, 1, 3'd7, 8'h85, 8'h00};
        vecs[7]  = '{8'h00, 0, 8'h00, 1, 0, 3'd0, 0, 3'd7, 8'h05, 8'h80};
        vecs[8]  = '{8'h00, 0, 8'h00, 0, 0, 3'd0, 0, 3'd7, 8'h05, 8'h80};
        vecs[9]  = '{8'h00, 0, 8'h00, 0, 0, 3'd0, 0, 3'd7, 8'h05, 8'h80};
        vecs[10] = '{8'h00, 0, 8'h00, 0, 1, 3'd7, 0, 3'd7, 8'h05, 8'h00};
        vecs[11] = '{8'h00, 0, 8'h00, 0, 0, 3'd0, 1, 3'd2, 8'h05, 8'h00};
        vecs[12] = '{8'h00, 0, 8'h00, 1, 0, 3'd0, 0, 3'd2, 8'h01, 8'h04};
        vecs[13] = '{8'h00, 0, 8'h00, 0, 1, 3'd2, 0, 3'd2, 8'h01, 8'h00};
        vecs[14] = '{8'h00, 0, 8'h00, 0, 0, 3'd0, 1, 3'd0, 8'h01, 8'h00};
        vecs[15] = '{8'h00, 0, 8'h00, 1, 0, 3'd0, 0, 3'd0, 8'h00, 8'h01};
        vecs[16] = '{8'h00, 0, 8'h00, 0, 1, 3'd0, 0, 3'd0, 8'h00, 8'h00};

        bus.irq = '0; bus.mask_we = 0; bus.mask_wdata = '0;
        bus.int_ack = 0; bus.eoi = 0; bus.eoi_id = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;

        // Directed table: single line, then 0x85 burst with nesting block.
        for (int v = 0; v < 17; v++) begin
            cyc(vecs[v].irq, vecs[v].mask_we, vecs[v].wdata, vecs[v].ack, vecs[v].eoi, vecs[v].eid);
            check($sformatf("vec%0d_valid", v), 32'(bus.int_valid), 32'(vecs[v].valid));
            check($sformatf("vec%0d_id", v), 32'(bus.int_id), 32'(vecs[v].id));
            check($sformatf("vec%0d_pending", v), 32'(bus.pending_o), 32'(vecs[v].pend));
            check($sformatf("vec%0d_in_service", v), 32'(bus.in_service_o), 32'(vecs[v].isr));
        end

        // Line 4 in service, lines 6 and 1 arrive.
        cyc(8'h10, 0, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 1, 0, 0);
        check("nest_isr4", 32'(bus.in_service_o), 32'h10);
        cyc(8'h42, 0, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0, 0);
        check("nest_valid6", 32'(bus.int_valid), 32'd1);
        check("nest_id6", 32'(bus.int_id), 32'd6);
        cyc(8'h00, 0, 0, 1, 0, 0);
        check("nest_isr64", 32'(bus.in_service_o), 32'h50);
        cyc(8'h00, 0, 0, 0, 0, 0);
        check("nest_blk1a", 32'(bus.int_valid), 32'd0);
        cyc(8'h00, 0, 0, 0, 1, 3'd6);
        cyc(8'h00, 0, 0, 0, 0, 0);
        check("nest_blk1b", 32'(bus.int_valid), 32'd0);
        check("nest_pend1", 32'(bus.pending_o), 32'h02);
        cyc(8'h00, 0, 0, 0, 1, 3'd4);
        cyc(8'h00, 0, 0, 0, 0, 0);
        check("nest_valid1", 32'(bus.int_valid), 32'd1);
        check("nest_id1", 32'(bus.int_id), 32'd1);
        cyc(8'h00, 0, 0, 1, 0, 0);
        cyc(8'h00, 0, 0, 0, 1, 3'd1);

        // Masked line latches pending; unmasking presents it two cycles later.
        cyc(8'h00, 1, 8'h00, 0, 0, 0);
        cyc(8'h20, 0, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0, 0);
        check("mask_novalid", 32'(bus.int_valid), 32'd0);
        check("mask_pend", 32'(bus.pending_o), 32'h20);
        cyc(8'h00, 1, 8'h20, 0, 0, 0);
        check("mask_wr_novalid", 32'(bus.int_valid), 32'd0);
        cyc(8'h00, 0, 0, 0, 0, 0);
        check("mask_valid5", 32'(bus.int_valid), 32'd1);
        check("mask_id5", 32'(bus.int_id), 32'd5);
        cyc(8'h00, 1, 8'hFF, 1, 0, 0);
        cyc(8'h00, 0, 0, 0, 1, 3'd5);

        // Higher line during REQ must not displace the presented id.
        cyc(8'h04, 0, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0, 0);
        cyc(8'h80, 0, 0, 0, 0, 0);
        check("hold_id2a", 32'(bus.int_id), 32'd2);
        cyc(8'h00, 0, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0, 0);
        check("hold_id2b", 32'(bus.int_id), 32'd2);
        check("hold_valid", 32'(bus.int_valid), 32'd1);
        cyc(8'h00, 0, 0, 1, 0, 0);
        check("hold_gap", 32'(bus.int_valid), 32'd0);
        cyc(8'h00, 0, 0, 0, 0, 0);
        check("hold_valid7", 32'(bus.int_valid), 32'd1);
        check("hold_id7", 32'(bus.int_id), 32'd7);
        cyc(8'h00, 0, 0, 1, 0, 0);
        cyc(8'h00, 0, 0, 0, 1, 3'd7);
        cyc(8'h00, 0, 0, 0, 1, 3'd2);

        // Reset mid-REQ with irq[0] held high.
        cyc(8'h01, 0, 0, 0, 0, 0);
        cyc(8'h01, 0, 0, 0, 0, 0);
        check("rst_pre_valid", 32'(bus.int_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("rst_async");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        reset_n = 1'b1;
        cyc(8'h01, 0, 0, 0, 0, 0);
        check("rst_pend0", 32'(bus.pending_o), 32'h01);
        cyc(8'h01, 0, 0, 0, 0, 0);
        check("rst_masked", 32'(bus.int_valid), 32'd0);
        cyc(8'h01, 1, 8'h01, 0, 0, 0);
        cyc(8'h01, 0, 0, 0, 0, 0);
        check("rst_valid0", 32'(bus.int_valid), 32'd1);
        check("rst_id0", 32'(bus.int_id), 32'd0);
        cyc(8'h00, 1, 8'hFF, 1, 0, 0);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            cyc(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                ($urandom_range(0, 15) == 0),
                8'($urandom),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0),
                3'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
